// File: rtl/slow_write_arbiter.sv
// Round-robin arbiter that shares one slow-clock write port among N_REQ fast-domain clients.
// The active-low strobe covers exactly one full synchronised high phase of slc.
module slow_write_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                slc,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] wdata,
  input  logic [N_REQ*AW-1:0] waddr,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic                busy,
  output logic                en_n,
  output logic [AW-1:0]       dev_addr,
  output logic [DW-1:0]       dev_data
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {StIdle, StSyncLo, StSyncHi, StStrobe, StDone} state_e;

  state_e            state_q, state_d;
  logic              slc_meta_q, s_slc;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic              en_n_q, en_n_d;
  logic              win_found;
  logic [PW-1:0]     win_idx;

  // Two-flop synchroniser; only s_slc may steer the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slc_meta_q <= 1'b0;
      s_slc      <= 1'b0;
    end else begin
      slc_meta_q <= slc;
      s_slc      <= slc_meta_q;
    end
  end

  // First requester at or above rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      int unsigned idx;
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d        = StSyncLo;
          win_d          = win_idx;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          addr_d         = waddr[win_idx*AW +: AW];
          data_d         = wdata[win_idx*DW +: DW];
        end
      end
      // Waiting for low first guarantees the strobe sees a whole high phase.
      StSyncLo: if (!s_slc) state_d = StSyncHi;
      StSyncHi: if (s_slc) state_d = StStrobe;
      StStrobe: if (!s_slc) state_d = StDone;
      StDone: begin
        state_d  = StIdle;
        gnt_d    = '0;
        rr_ptr_d = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + PW'(1);
      end
      default: state_d = StIdle;
    endcase
    en_n_d = (state_d != StStrobe);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      win_q    <= '0;
      gnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      en_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      en_n_q   <= en_n_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = (state_q == StDone) ? gnt_q : '0;
  assign busy     = (state_q != StIdle);
  assign en_n     = en_n_q;
  assign dev_addr = addr_q;
  assign dev_data = data_q;

endmodule
